// File: rtl/clk_bringup_seq.sv
// AD9516 clock bring-up sequencer: power-up wait, timed configuration attempts with
// retries, a lock-stability window before READY, and loss-of-lock supervision.
module clk_bringup_seq #(
    parameter int unsigned PWRUP_CYC        = 1000,
    parameter int unsigned LOCK_TIMEOUT_CYC = 200000,
    parameter int unsigned MAX_RETRY        = 3,
    parameter int unsigned STABLE_CYC       = 256,
    parameter int unsigned REARM_CYC        = 16,
    parameter int unsigned LOL_CYC          = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lock_i,
    input  logic       restart_i,
    output logic       set_ad9516,
    output logic       clk_ready,
    output logic       fail,
    output logic       lol_pulse,
    output logic [2:0] retry_cnt,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_PWRUP  = 3'd0,
        ST_HOLD   = 3'd1,
        ST_CONFIG = 3'd2,
        ST_STABLE = 3'd3,
        ST_READY  = 3'd4,
        ST_FAIL   = 3'd5
    } state_e;

    localparam logic [23:0] PWRUP_LAST   = 24'(PWRUP_CYC - 1);
    localparam logic [23:0] REARM_LAST   = 24'(REARM_CYC - 1);
    localparam logic [23:0] TIMEOUT_LAST = 24'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [23:0] STABLE_LAST  = 24'(STABLE_CYC - 1);
    localparam logic [23:0] LOL_LAST     = 24'(LOL_CYC - 1);
    localparam logic [2:0]  RETRY_LIMIT  = 3'(MAX_RETRY);

    state_e      state_q, state_d;
    logic [23:0] timer_q, timer_d;
    logic [23:0] count_q, count_d;
    logic [2:0]  retry_q, retry_d;
    logic        set_q, set_d;
    logic        ready_q, ready_d;
    logic        fail_q, fail_d;
    logic        lol_q, lol_d;
    logic        lolEvent;
    logic        attemptTimeout;

    // count_q is the stability counter in STABLE and the unlock counter in READY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_PWRUP;
            timer_q <= '0;
            count_q <= '0;
            retry_q <= '0;
            set_q   <= 1'b0;
            ready_q <= 1'b0;
            fail_q  <= 1'b0;
            lol_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            retry_q <= retry_d;
            set_q   <= set_d;
            ready_q <= ready_d;
            fail_q  <= fail_d;
            lol_q   <= lol_d;
        end
    end

    assign attemptTimeout = (timer_q >= TIMEOUT_LAST);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + 24'd1;
        count_d  = count_q;
        retry_d  = retry_q;
        lolEvent = 1'b0;
        if (restart_i) begin
            state_d = ST_HOLD;
            timer_d = '0;
            count_d = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_PWRUP: begin
                    if (timer_q == PWRUP_LAST) begin
                        state_d = ST_CONFIG;
                        timer_d = '0;
                    end
                end
                ST_HOLD: begin
                    if (timer_q == REARM_LAST) begin
                        state_d = ST_CONFIG;
                        timer_d = '0;
                    end
                end
                // The attempt timer keeps running across CONFIG <-> STABLE hops.
                ST_CONFIG, ST_STABLE: begin
                    if (attemptTimeout) begin
                        timer_d = '0;
                        count_d = '0;
                        if (retry_q == RETRY_LIMIT) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_HOLD;
                            retry_d = (retry_q == 3'd7) ? retry_q : retry_q + 3'd1;
                        end
                    end else if (state_q == ST_CONFIG) begin
                        if (lock_i) begin
                            state_d = ST_STABLE;
                            count_d = '0;
                        end
                    end else if (!lock_i) begin
                        state_d = ST_CONFIG;
                    end else if (count_q == STABLE_LAST) begin
                        state_d = ST_READY;
                        timer_d = '0;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 24'd1;
                    end
                end
                ST_READY: begin
                    if (lock_i) begin
                        count_d = '0;
                    end else if (count_q == LOL_LAST) begin
                        state_d  = ST_HOLD;
                        timer_d  = '0;
                        count_d  = '0;
                        retry_d  = '0;
                        lolEvent = 1'b1;
                    end else begin
                        count_d = count_q + 24'd1;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_HOLD;
                    timer_d = '0;
                    count_d = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they track state_q exactly.
    always_comb begin
        set_d   = (state_d == ST_CONFIG) || (state_d == ST_STABLE) || (state_d == ST_READY);
        ready_d = (state_d == ST_READY);
        fail_d  = (state_d == ST_FAIL);
        lol_d   = lolEvent;
    end

    assign set_ad9516 = set_q;
    assign clk_ready  = ready_q;
    assign fail       = fail_q;
    assign lol_pulse  = lol_q;
    assign retry_cnt  = retry_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_clk_bringup_seq.sv
// Self-checking bench for clk_bringup_seq: randomized lock timing against expectations
// derived arithmetically from the bring-up rules.
module tb_clk_bringup_seq;

    localparam int PWRUP     = 8;
    localparam int TMO       = 100;
    localparam int RETRIES   = 2;
    localparam int STABLE    = 16;
    localparam int REARM     = 4;
    localparam int LOL       = 4;
    localparam int GLITCH_AT = 10;

    localparam int S_PWRUP  = 0;
    localparam int S_HOLD   = 1;
    localparam int S_CONFIG = 2;
    localparam int S_STABLE = 3;
    localparam int S_READY  = 4;
    localparam int S_FAIL   = 5;

    logic       clk;
    logic       rst_n;
    logic       lock_i;
    logic       restart_i;
    logic       set_ad9516;
    logic       clk_ready;
    logic       fail;
    logic       lol_pulse;
    logic [2:0] retry_cnt;
    logic [2:0] state_o;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    clk_bringup_seq #(
        .PWRUP_CYC       (PWRUP),
        .LOCK_TIMEOUT_CYC(TMO),
        .MAX_RETRY       (RETRIES),
        .STABLE_CYC      (STABLE),
        .REARM_CYC       (REARM),
        .LOL_CYC         (LOL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lock_i    (lock_i),
        .restart_i (restart_i),
        .set_ad9516(set_ad9516),
        .clk_ready (clk_ready),
        .fail      (fail),
        .lol_pulse (lol_pulse),
        .retry_cnt (retry_cnt),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Edges from lock_i rising to clk_ready: one to notice the lock, then the full stable window.
    function automatic int lockToReady();
        return 1 + STABLE;
    endfunction

    // Edges from attempt start to READY when lock comes at d and glitches once at GLITCH_AT.
    function automatic int glitchEdges(input int d);
        return d + 1 + GLITCH_AT + 1 + lockToReady();
    endfunction

    // The TMO-th edge of an attempt is the timeout, which wins over reaching READY.
    function automatic bit glitchSucceeds(input int d);
        return glitchEdges(d) < TMO;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input logic lock, input logic restart);
        lock_i    = lock;
        restart_i = restart;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Counts cycles for which set_ad9516 holds the given level, starting with the current one.
    task automatic runLength(input logic level, input int limit, output int n);
        n = 0;
        while (set_ad9516 === level && n < limit) begin
            n++;
            tick();
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_state"}, int'(state_o), S_PWRUP);
        checkOutput({tag, "_set"}, int'(set_ad9516), 0);
        checkOutput({tag, "_ready"}, int'(clk_ready), 0);
        checkOutput({tag, "_fail"}, int'(fail), 0);
        checkOutput({tag, "_lol"}, int'(lol_pulse), 0);
        checkOutput({tag, "_retry"}, int'(retry_cnt), 0);
    endtask

    task automatic glitchRun(input string tag, input int d);
        int start;
        start = cyc;
        repeat (d) tick();
        applyStimulus(1'b1, 1'b0);
        tick();
        checkOutput({tag, "_stable"}, int'(state_o), S_STABLE);
        repeat (GLITCH_AT) tick();
        applyStimulus(1'b0, 1'b0);
        tick();
        checkOutput({tag, "_back_config"}, int'(state_o), S_CONFIG);
        checkOutput({tag, "_set_held"}, int'(set_ad9516), 1);
        applyStimulus(1'b1, 1'b0);
        while (!(clk_ready === 1'b1 || state_o === 3'(S_HOLD)) && (cyc - start) < 400) tick();
        if (glitchSucceeds(d)) begin
            checkOutput({tag, "_ready_edge"}, cyc - start, glitchEdges(d));
            checkOutput({tag, "_ready_state"}, int'(state_o), S_READY);
            checkOutput({tag, "_retry"}, int'(retry_cnt), 0);
        end else begin
            checkOutput({tag, "_timeout_edge"}, cyc - start, TMO);
            checkOutput({tag, "_timeout_state"}, int'(state_o), S_HOLD);
            checkOutput({tag, "_retry"}, int'(retry_cnt), 1);
        end
    endtask

    initial begin
        int n;
        int d;
        int k;
        applyStimulus(1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (3) tick();
        checkResetValues("reset");

        // Nominal bring-up with a randomized lock delay.
        rst_n = 1'b1;
        runLength(1'b0, 1000, n);
        checkOutput("pwrup_len", n, PWRUP);
        checkOutput("config_state", int'(state_o), S_CONFIG);
        d = $urandom_range(20, 60);
        repeat (d) tick();
        applyStimulus(1'b1, 1'b0);
        n = 0;
        while (clk_ready !== 1'b1 && n < 500) begin
            n++;
            tick();
        end
        checkOutput("lock_to_ready", n, lockToReady());
        checkOutput("ready_state", int'(state_o), S_READY);
        checkOutput("ready_set", int'(set_ad9516), 1);
        checkOutput("ready_retry", int'(retry_cnt), 0);

        // Short unlock bursts are tolerated.
        k = $urandom_range(1, LOL - 1);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < k; i++) begin
            tick();
            checkOutput("short_drop_ready", int'(clk_ready), 1);
            checkOutput("short_drop_lol", int'(lol_pulse), 0);
        end
        applyStimulus(1'b1, 1'b0);
        repeat (2) tick();
        checkOutput("short_drop_recover", int'(clk_ready), 1);

        // A full LOL_CYC unlock burst drops back to HOLD.
        applyStimulus(1'b0, 1'b0);
        repeat (LOL - 1) tick();
        checkOutput("lol_pre_ready", int'(clk_ready), 1);
        tick();
        checkOutput("lol_pulse", int'(lol_pulse), 1);
        checkOutput("lol_ready", int'(clk_ready), 0);
        checkOutput("lol_state", int'(state_o), S_HOLD);
        checkOutput("lol_retry", int'(retry_cnt), 0);
        tick();
        checkOutput("lol_single", int'(lol_pulse), 0);
        runLength(1'b0, 50, n);
        checkOutput("lol_gap", n + 1, REARM);

        // No lock at all: every attempt times out until FAIL.
        for (int att = 1; att <= RETRIES + 1; att++) begin
            runLength(1'b1, 1000, n);
            checkOutput("attempt_len", n, TMO);
            if (att <= RETRIES) begin
                checkOutput("attempt_retry", int'(retry_cnt), att);
                checkOutput("attempt_hold", int'(state_o), S_HOLD);
                runLength(1'b0, 50, n);
                checkOutput("attempt_gap", n, REARM);
            end else begin
                checkOutput("fail_flag", int'(fail), 1);
                checkOutput("fail_set", int'(set_ad9516), 0);
                checkOutput("fail_state", int'(state_o), S_FAIL);
                checkOutput("fail_retry", int'(retry_cnt), RETRIES);
            end
        end
        repeat ($urandom_range(5, 40)) tick();
        checkOutput("fail_sticky", int'(fail), 1);

        // Restart out of FAIL.
        applyStimulus(1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("restart_state", int'(state_o), S_HOLD);
        checkOutput("restart_fail", int'(fail), 0);
        checkOutput("restart_retry", int'(retry_cnt), 0);
        runLength(1'b0, 50, n);
        checkOutput("restart_gap", n, REARM);

        // Lock glitch inside the settle window, once early and once near the budget edge.
        glitchRun("glitch_early", $urandom_range(2, 20));
        applyStimulus(1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        runLength(1'b0, 50, n);
        checkOutput("restart_ready_gap", n, REARM);
        glitchRun("glitch_late", $urandom_range(60, 85));

        // Asynchronous reset while in STABLE.
        applyStimulus(1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        runLength(1'b0, 50, n);
        applyStimulus(1'b1, 1'b0);
        tick();
        checkOutput("pre_reset_stable", int'(state_o), S_STABLE);
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("async_reset");
        repeat (2) tick();
        rst_n = 1'b1;
        runLength(1'b0, 1000, n);
        checkOutput("repwrup_len", n, PWRUP);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
